// File: rtl/switch_reg_loader_pkg.sv
// Shared types and limits for the switch-driven register loader.
// Optional build macro used by the top: SWITCH_REG_LOADER_BCD_CHECK_EN.
package switch_reg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WRITE        = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  localparam logic [3:0] REG_SEL_MIN = 4'd1;
  localparam logic [3:0] REG_SEL_MAX = 4'd9;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  function automatic logic sel_in_range(input logic [3:0] sel);
    return (sel >= REG_SEL_MIN) && (sel <= REG_SEL_MAX);
  endfunction

endpackage

// File: rtl/switch_reg_loader_debounce.sv
// button_debounce: 2-flop synchroniser, saturating stable-sample counter and
// rising-edge detector for a raw board push-button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_reg;
  logic             stable_reg;
  logic             rise_reg;
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg   <= 2'b00;
      stable_reg <= 1'b0;
      rise_reg   <= 1'b0;
      count_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      rise_reg <= 1'b0;
      if (sync_reg[1] == stable_reg) begin
        count_reg <= '0;
      end else if (count_reg >= CNT_LAST) begin
        // This cycle is the last of the required run of differing samples.
        stable_reg <= sync_reg[1];
        rise_reg   <= sync_reg[1];
        count_reg  <= '0;
      end else if (count_reg != CNT_MAX) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign stable = stable_reg;
  assign rise   = rise_reg;

endmodule

// File: rtl/switch_reg_loader.sv
// Loads a switch-selected register with a BCD digit on a debounced button press.
// Define SWITCH_REG_LOADER_BCD_CHECK_EN to also reject digits above 9.
module switch_reg_loader
  import switch_reg_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ADDR_W          = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [3:0]        SW,
  input  logic [3:0]        DIGIT,
  input  logic              BTN,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err
);

  logic              btn_stable;
  logic              btn_rise;
  logic              load_ok;
  state_t            state_reg;
  logic              wr_valid_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [31:0]       wr_data_reg;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (BTN),
    .stable (btn_stable),
    .rise   (btn_rise)
  );

  always_comb begin
    load_ok = sel_in_range(SW);
`ifdef SWITCH_REG_LOADER_BCD_CHECK_EN
    if (DIGIT > BCD_MAX) load_ok = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      wr_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (btn_rise) begin
            if (load_ok) begin
              wr_addr_reg  <= ADDR_W'(SW);
              wr_data_reg  <= 32'(DIGIT);
              wr_valid_reg <= 1'b1;
              state_reg    <= WRITE;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= WAIT_RELEASE;
            end
          end
        end
        WRITE: begin
          if (wr_ready) begin
            wr_valid_reg <= 1'b0;
            state_reg    <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          // Presses seen while busy are dropped, not queued.
          if (!btn_stable) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wr_valid = wr_valid_reg;
  assign err      = err_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;

endmodule

// File: tb/tb_switch_reg_loader.sv
// Scoreboard bench for switch_reg_loader with DEBOUNCE_CYCLES=4.
module tb_switch_reg_loader;

  localparam int DEB = 4;
  localparam int AW  = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [3:0]    SW;
  logic [3:0]    DIGIT;
  logic          BTN;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          err;

  switch_reg_loader #(.DEBOUNCE_CYCLES(DEB), .ADDR_W(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .SW      (SW),
    .DIGIT   (DIGIT),
    .BTN     (BTN),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .err     (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_err;
    logic [31:0] addr;
    logic [31:0] data;
    int          width;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   events_seen = 0;
  bit   ready_pre = 0;
  bit   ready_hold = 0;
  int   cur_delay = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: a load is accepted iff the select is 1..9 (and, with the
  // BCD check built in, the digit is 0..9); valid lasts delay+1 cycles.
  function automatic exp_t model(input int sw, input int dig, input int delay, input bit pre);
    exp_t e;
    bit ok;
    ok = (sw >= 1) && (sw <= 9);
`ifdef SWITCH_REG_LOADER_BCD_CHECK_EN
    if (dig > 9) ok = 0;
`endif
    e.is_err = !ok;
    e.addr   = sw;
    e.data   = dig;
    e.width  = pre ? 1 : delay + 1;
    return e;
  endfunction

  // wr_ready driver: constant-high mode, or raised after cur_delay valid cycles.
  initial begin
    int wcnt;
    wr_ready = 1'b0;
    wcnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (ready_pre) wr_ready = 1'b1;
      else if (ready_hold || !wr_valid) begin
        wr_ready = 1'b0;
        wcnt = 0;
      end else if (wcnt >= cur_delay) wr_ready = 1'b1;
      else wcnt++;
    end
  end

  task automatic pop_check(input bit act_is_err, input int vlen);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event actual=%s required=none", act_is_err ? "err" : "write");
    end else begin
      e = exp_q.pop_front();
      check("event_is_err", 32'(act_is_err), 32'(e.is_err));
      if (!act_is_err && !e.is_err) begin
        check("wr_addr", 32'(wr_addr), e.addr);
        check("wr_data", wr_data, e.data);
        check("valid_width", vlen, e.width);
      end
      $display("txn %s addr=%0d data=%0d width=%0d", act_is_err ? "err" : "write",
               wr_addr, wr_data, vlen);
    end
  endtask

  // Monitor: pops the scoreboard on every write handshake or err pulse.
  initial begin
    int          vlen;
    bit          prev_err;
    logic [31:0] prev_addr, prev_data;
    vlen = 0;
    prev_err = 0;
    prev_addr = 0;
    prev_data = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        vlen = 0;
        prev_err = 0;
      end else begin
        if (wr_valid) begin
          vlen++;
          if (vlen > 1) begin
            check("hold_addr", 32'(wr_addr), prev_addr);
            check("hold_data", wr_data, prev_data);
          end
          prev_addr = 32'(wr_addr);
          prev_data = wr_data;
        end
        if (err) begin
          events_seen++;
          check("err_single_cycle", 32'(prev_err), 32'd0);
          if (!prev_err) pop_check(1'b1, 0);
        end
        if (wr_valid && wr_ready) begin
          events_seen++;
          pop_check(1'b0, vlen);
          vlen = 0;
        end
        prev_err = err;
      end
    end
  end

  task automatic press(input int sw, input int dig, input int delay, input bit pre,
                       input int hold, input int sw2, input int dig2);
    int i;
    exp_q.push_back(model(sw, dig, delay, pre));
    ready_pre = pre;
    cur_delay = delay;
    SW = 4'(sw);
    DIGIT = 4'(dig);
    BTN = 1'b1;
    for (i = 0; i < 20 && !(wr_valid || err); i++) @(negedge clock);
    if (!(wr_valid || err)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL press_timeout actual=none required=event");
    end
    SW = 4'(sw2);
    DIGIT = 4'(dig2);
    repeat (hold) @(negedge clock);
    BTN = 1'b0;
    for (i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (12) @(negedge clock);
    ready_pre = 0;
  endtask

  task automatic glitch(input int len);
    int snap;
    snap = events_seen;
    BTN = 1'b1;
    repeat (len) @(negedge clock);
    BTN = 1'b0;
    repeat (12) @(negedge clock);
    check("glitch_events", events_seen, snap);
    $display("txn glitch len=%0d events=%0d", len, events_seen - snap);
  endtask

  initial begin
    int snap, cnt;
    reset_n = 1'b0;
    BTN = 1'b0;
    SW = 4'd0;
    DIGIT = 4'd0;
    repeat (3) @(negedge clock);
    check("reset_wr_valid", 32'(wr_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);
    check("reset_wr_data", wr_data, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    press(3, 7, 0, 1, 6, 3, 7);
    glitch(2);
    press(5, 2, 6, 0, 2, 8, 4);
    press(0, 4, 0, 0, 3, 1, 1);
    press(12, 4, 0, 0, 3, 2, 2);
    press(9, 11, 0, 1, 3, 0, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, 3));
      press($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 5),
            $urandom_range(0, 3) == 0, $urandom_range(0, 8),
            $urandom_range(0, 15), $urandom_range(0, 15));
    end

    // Reset while a write is stalled: the write must be dropped.
    ready_hold = 1;
    SW = 4'd4;
    DIGIT = 4'd6;
    BTN = 1'b1;
    for (int i = 0; i < 20 && !wr_valid; i++) @(negedge clock);
    check("stall_valid_seen", 32'(wr_valid), 32'd1);
    snap = events_seen;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(wr_valid), 32'd0);
    check("async_reset_addr", 32'(wr_addr), 32'd0);
    BTN = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    ready_hold = 0;
    repeat (20) @(negedge clock);
    check("no_write_after_reset", events_seen, snap);
    check("valid_low_after_reset", 32'(wr_valid), 32'd0);
    $display("txn reset_during_write events=%0d", events_seen - snap);

    // Button held through reset: press only after full debounce.
    SW = 4'd2;
    DIGIT = 4'd4;
    BTN = 1'b1;
    #2 reset_n = 1'b0;
    exp_q.push_back(model(2, 4, 0, 1));
    ready_pre = 1;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20 && !wr_valid; i++) begin
      @(posedge clock);
      #1;
      cnt++;
    end
    check("held_reset_latency", cnt, 7);
    $display("txn held_through_reset latency=%0d", cnt);
    BTN = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    repeat (12) @(negedge clock);
    ready_pre = 0;

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/switch_reg_loader.md
SWITCH_REG_LOADER -- requirements
Module: switch_reg_loader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, stable-sample count for button debounce (10 ms at 25 MHz).
REQ-002 SHALL have parameter ADDR_W, default 5, register-file address width.
REQ-003 SHALL have port clock  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port SW  input  4  target register select, same encoding as the display select (1..9 valid).
REQ-006 SHALL have port DIGIT  input  4  value to load, BCD digit.
REQ-007 SHALL have port BTN  input  1  raw, unsynchronised load push-button, active-high.
REQ-008 SHALL have port wr_valid  output  1  write request to register file.
REQ-009 SHALL have port wr_ready  input  1  register file accepts write.
REQ-010 SHALL have port wr_addr  output  ADDR_W  target register index.
REQ-011 SHALL have port wr_data  output  32  value to write.
REQ-012 SHALL have port err  output  1  one-cycle pulse on rejected load.

Function
REQ-013 SHALL pass BTN through a 2-flop synchroniser before any use.
REQ-014 SHALL debounce: a counter clears whenever the synchronised level equals the stable level; the stable level flips when the synchronised level has differed for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 SHALL generate one press event on the stable level's 0->1 transition only.
REQ-016 SHALL implement FSM IDLE, WRITE, WAIT_RELEASE.
REQ-017 IDLE + press + SW in 1..9: capture SW and DIGIT same cycle, go WRITE; wr_valid high the following cycle.
REQ-018 IDLE + press + SW outside 1..9: no write, err high exactly one cycle, go WAIT_RELEASE.
REQ-019 WRITE: wr_valid, wr_addr, wr_data held constant until the cycle wr_valid && wr_ready; then go WAIT_RELEASE, wr_valid low next cycle.
REQ-020 wr_ready already high on first WRITE cycle SHALL complete in that cycle (one-cycle valid pulse).
REQ-021 WAIT_RELEASE: stay until stable level is 0, then IDLE; presses are never queued.
REQ-022 wr_addr SHALL be captured SW zero-extended to ADDR_W; wr_data captured DIGIT zero-extended to 32 bits.
REQ-023 SW/DIGIT changes after capture SHALL NOT affect the pending write.
REQ-024 Debounce counter SHALL saturate, never wrap; width ceil(log2(DEBOUNCE_CYCLES+1)).

Reset
REQ-025 reset_n low SHALL asynchronously force: FSM IDLE, wr_valid 0, err 0, wr_addr 0, wr_data 0, synchroniser and stable level 0, counter 0.
REQ-026 Reset during WRITE SHALL abandon the write; no write issued after release.
REQ-027 Button held through reset release SHALL produce a press only after full debounce from reset.

Configuration
REQ-028 Macro SWITCH_REG_LOADER_BCD_CHECK_EN defined: DIGIT > 9 at press SHALL be rejected as in REQ-018.
REQ-029 Macro undefined: any DIGIT 0..15 SHALL be written; err raised only for invalid SW.

Structure
REQ-030 Shared package SHALL hold the FSM state enum, REG_SEL_MIN=1, REG_SEL_MAX=9, BCD_MAX=9.
REQ-031 Synchroniser, debounce counter and edge detector SHALL be sub-module button_debounce (ports clock, reset_n, raw, stable, rise), reusable for other board buttons.
REQ-032 Top FSM, capture registers and handshake SHALL reside in switch_reg_loader.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 SW=3, DIGIT=7, BTN high 10 cycles, wr_ready=1 -> one wr_valid pulse, wr_addr=3, wr_data=7; no second write while held.
REQ-034 BTN glitches high 2 cycles then low -> no wr_valid, no err.
REQ-035 SW=5, DIGIT=2, wr_ready=0 for 6 cycles then 1; SW changed to 8 meanwhile -> wr_valid held 7 cycles, wr_addr=5 throughout, write completes once.
REQ-036 SW=0 or SW=12, press -> err single-cycle pulse, wr_valid stays 0.
REQ-037 SW=9, DIGIT=11, press -> with BCD_CHECK_EN: err pulse, no write; without: write wr_addr=9, wr_data=11.
REQ-038 reset_n low during WRITE with wr_ready=0 -> wr_valid 0 immediately (asynchronously); after release with BTN low, no write occurs.
